paralelo_serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 15 +
 rtl/paralelo_serial_tx.sv | 101 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and receiver.
//   WIDTH_DEF       default frame width in bits
//   COMMA_SYM       alignment / idle symbol
//   IDLE_COMMAS_DEF COMMA frames forced after reset
//   tx_state_e      transmitter FSM encoding (SYNC, ACTIVE)
package serial_pkg;
  localparam int         WIDTH_DEF       = 8;
  localparam logic [7:0] COMMA_SYM       = 8'hBC;
  localparam int         IDLE_COMMAS_DEF = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;
endpackage

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: parallel-to-serial transmitter, one bit per clk_32f
// cycle, WIDTH-bit frames sent LSB first. After reset it sends IDLE_COMMAS
// COMMA frames, then sends user bytes offered on ready and fills every empty
// frame with COMMA.
//
// Ports:
//   clk_32f     in   bit clock, rising edge
//   reset       in   synchronous, active-high
//   data_in     in   byte to transmit
//   valid_in    in   data_in valid, sampled only while ready is high
//   ready       out  combinational, last bit cycle of a frame that may carry data
//   data_out    out  registered serial bit
//   active_tx   out  registered, high once the sync run is complete
//   frames_sent out  (only with TX_FRAME_CNT_EN) saturating count of data frames
//
// Build option: define TX_FRAME_CNT_EN to add the frames_sent counter.
module paralelo_serial_tx
  import serial_pkg::*;
#(
  parameter int               WIDTH       = WIDTH_DEF,
  parameter logic [WIDTH-1:0] COMMA       = COMMA_SYM,
  parameter int               IDLE_COMMAS = IDLE_COMMAS_DEF
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             data_out,
  output logic             active_tx
`ifdef TX_FRAME_CNT_EN
  ,
  output logic [15:0]      frames_sent
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  tx_state_e        state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       comma_cnt, comma_nxt;
  logic [WIDTH-1:0] frame_reg, frame_nxt;
  logic             boundary;
  logic             sync_done;
  logic             load_data;

  assign boundary  = (bit_cnt == LAST_BIT);
  assign sync_done = (comma_cnt == 4'(IDLE_COMMAS));

  // FSM state register
  always_ff @(posedge clk_32f) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  // Next state, next frame and ready. The last sync boundary already uses
  // the data rule, so the first user byte can follow the commas with no gap.
  always_comb begin
    state_nxt = state;
    comma_nxt = comma_cnt;
    frame_nxt = frame_reg;
    load_data = 1'b0;
    ready     = boundary && ((state == ACTIVE) || sync_done);
    if (ready) begin
      state_nxt = ACTIVE;
      load_data = valid_in;
      frame_nxt = valid_in ? data_in : COMMA;
    end else if (boundary) begin
      frame_nxt = COMMA;
      comma_nxt = comma_cnt + 4'd1;
    end
  end

  // Datapath: serializer, bit counter, sync comma counter
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      data_out  <= 1'b0;
      active_tx <= 1'b0;
      bit_cnt   <= '0;
      comma_cnt <= 4'd1;   // frame loaded at reset is the first comma
      frame_reg <= COMMA;
    end else begin
      data_out  <= frame_reg[bit_cnt];
      active_tx <= (state_nxt == ACTIVE);
      bit_cnt   <= boundary ? '0 : bit_cnt + CW'(1);
      comma_cnt <= comma_nxt;
      frame_reg <= frame_nxt;
    end
  end

`ifdef TX_FRAME_CNT_EN
  always_ff @(posedge clk_32f) begin
    if (reset)
      frames_sent <= 16'd0;
    else if (load_data && (frames_sent != 16'hFFFF))
      frames_sent <= frames_sent + 16'd1;
  end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: randomized self-checking bench for paralelo_serial_tx.
// The model works from edge counts since reset: frame f = (edge-1)/8 carries
// COMMA for f < IDLE_COMMAS, otherwise the byte accepted at edge 8*f (or COMMA).
module tb_paralelo_serial_tx;
  localparam int         IDLE  = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset, valid_in, ready, data_out, active_tx;
  logic [7:0] data_in;
`ifdef TX_FRAME_CNT_EN
  logic [15:0] frames_sent;
`endif

  paralelo_serial_tx dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready    (ready),
    .data_out (data_out),
    .active_tx(active_tx)
`ifdef TX_FRAME_CNT_EN
    , .frames_sent(frames_sent)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         k = -1;         // edges since last reset edge, -1 before first reset
  logic [7:0] fbyte[int];     // accepted data byte per frame index
  logic       exp_out = 1'b0;
  logic       exp_act = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  logic [63:0] hist = '0;     // lane history, newest bit at LSB

  function automatic logic model_ready(input int kk);
    return (kk >= 0) && (kk % 8 == 7) && (kk + 1 >= 8 * IDLE);
  endfunction

  initial forever begin
    @(posedge clk_32f);
    if (reset) begin
      k = 0; fbyte.delete(); exp_out = 1'b0; exp_act = 1'b0; exp_cnt = 16'd0;
    end else if (k >= 0) begin
      int e, fr, pos;
      logic [7:0] b;
      e   = k + 1;
      fr  = (e - 1) / 8;
      pos = (e - 1) % 8;
      b   = (fr < IDLE || !fbyte.exists(fr)) ? COMMA : fbyte[fr];
      exp_out = b[pos];
      if (model_ready(k) && valid_in) begin
        fbyte[e / 8] = data_in;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end
      k = e;
      exp_act = (k >= 8 * IDLE);
    end
  end

  initial forever begin
    @(posedge clk_32f);
    #1 hist = {hist[62:0], data_out};
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_32f);
    if (k >= 0) begin
      chk("data_out", 64'(data_out), 64'(exp_out));
      chk("active_tx", 64'(active_tx), 64'(exp_act));
      chk("ready", 64'(ready), 64'(model_ready(k)));
`ifdef TX_FRAME_CNT_EN
      chk("frames_sent", 64'(frames_sent), 64'(exp_cnt));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk_32f);
      n++;
    end
    n_cmp++;
    if (!ready) begin
      n_err++;
      $display("FAIL wait_ready: ready=%0b required 1 within 20 cycles", ready);
    end
  endtask

  // Two bytes on consecutive ready cycles, then one idle frame; exp is the
  // lane image of the three frames, first bit transmitted at the MSB.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic [23:0] exp);
    wait_ready();
    valid_in = 1'b1; data_in = a;
    @(negedge clk_32f);
    valid_in = 1'b0;
    repeat (7) @(negedge clk_32f);
    valid_in = 1'b1; data_in = b;
    @(negedge clk_32f);
    valid_in = 1'b0;
    repeat (16) @(negedge clk_32f);
    chk("lane_pair", 64'(hist[23:0]), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk_32f);
    chk("reset_data_out", 64'(data_out), 64'd0);
    chk("reset_active", 64'(active_tx), 64'd0);
    reset = 1'b0;

    // sync run: 8 COMMA frames with no data offered
    repeat (23) @(negedge clk_32f);
    chk("ready_e23", 64'(ready), 64'd0);
    repeat (8) @(negedge clk_32f);
    chk("ready_e31", 64'(ready), 64'd1);
    chk("active_e31", 64'(active_tx), 64'd0);
    @(negedge clk_32f);
    chk("active_e32", 64'(active_tx), 64'd1);
    chk("ready_e32", 64'(ready), 64'd0);
    repeat (32) @(negedge clk_32f);
    chk("lane_sync", hist, {8{8'h3D}});

    // 0xFF then 0x00 back to back, then COMMA
    send_pair(8'hFF, 8'h00, 24'hFF003D);

    // byte offered only during non-ready cycles is dropped
    wait_ready();
    @(negedge clk_32f);
    valid_in = 1'b1; data_in = 8'h5A;
    repeat (7) @(negedge clk_32f);
    valid_in = 1'b0;
    repeat (9) @(negedge clk_32f);
    chk("lane_ignore", 64'(hist[15:0]), 64'h3D3D);

    // 0x3C, 0xA5 with no gap
    send_pair(8'h3C, 8'hA5, 24'h3CA53D);

    // randomized traffic; valid_in also toggles off the ready cycle
    for (int i = 0; i < 400; i++) begin
      data_in = 8'($urandom);
      valid_in = ready ? 1'($urandom) : ($urandom_range(0, 3) == 0);
      @(negedge clk_32f);
    end
    valid_in = 1'b0;

    // reset mid data frame at bit_cnt==3
    wait_ready();
    valid_in = 1'b1; data_in = 8'h96;
    @(negedge clk_32f);
    valid_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    chk("midrst_data_out", 64'(data_out), 64'd0);
    chk("midrst_active", 64'(active_tx), 64'd0);
    reset = 1'b0;
    repeat (31) @(negedge clk_32f);
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_active_pre", 64'(active_tx), 64'd0);
    @(negedge clk_32f);
    chk("midrst_active_post", 64'(active_tx), 64'd1);

`ifdef TX_FRAME_CNT_EN
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      valid_in = 1'b1; data_in = 8'($urandom);
      @(negedge clk_32f);
      valid_in = 1'b0;
      repeat (8) @(negedge clk_32f);
    end
    chk("frames_5", 64'(frames_sent), 64'd5);
    #1;
    force dut.frames_sent = 16'hFFFE;
    #1;
    release dut.frames_sent;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      valid_in = 1'b1; data_in = 8'($urandom);
      @(negedge clk_32f);
      valid_in = 1'b0;
    end
    @(negedge clk_32f);
    chk("frames_sat", 64'(frames_sent), 64'hFFFF);
`endif

    repeat (16) @(negedge clk_32f);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
